// File: rtl/rsa_rfid_pkg.sv
// Shared constants, FSM state type and CRC step for the rsa_rfid transmit path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rsa_rfid_pkg;

    localparam logic [7:0]  PREAMBLE   = 8'hAC;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        CRC,
        GAP
    } tx_state_t;

    // One bit of an unreflected MSB-first CRC-16 (poly 0x1021).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        return (crc[15] ^ din) ? (shifted ^ CRC16_POLY) : shifted;
    endfunction

endpackage

// File: rtl/rsa_tx_fifo.sv
// Synchronous show-ahead FIFO holding ciphertext bytes for the framer.
// Latency: push visible in count one cycle later; head (pop_data) is combinational.
// Backpressure: push on full is refused unless a pop happens in the same cycle.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data, full, empty, count.
module rsa_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rsa_tx_framer.sv
// Buffers RSA ciphertext bytes and serializes preamble + payload + ~CRC-16 frames on tx_bit.
// Latency: frame starts the cycle after IDLE sees tx_en with a full payload buffered.
// Backpressure: none upstream; bytes arriving on a full FIFO are dropped and flag overflow.
// Ports: clk, reset (async active-low), done/output_text (byte in), tx_en,
//        tx_bit/tx_valid/frame_done (line out), overflow (sticky), fifo_count.
// Build option: define RSA_TX_FM0_EN for an FM0-encoded tx_bit; otherwise NRZ.
module rsa_tx_framer
    import rsa_rfid_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int BYTES_PER_FRAME = 2,
    parameter int BIT_DIV         = 4,
    parameter int GAP_BITS        = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done,
    input  logic [DATA_W-1:0]           output_text,
    input  logic                        tx_en,
    output logic                        tx_bit,
    output logic                        tx_valid,
    output logic                        frame_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int DW       = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PAY_BITS = DATA_W * BYTES_PER_FRAME;
    localparam int CNT_W    = $clog2(PAY_BITS + GAP_BITS + 24 + 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DW-1:0]     div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BW-1:0]     byte_bit;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] head;
    logic [15:0]       crc;
    logic              bit_end;
    logic              last_bit;
    logic              cur_bit;
    logic              pop_now;
    logic              pop_req;
    logic              fifo_full;
    logic              fifo_empty;

    rsa_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (done),
        .push_data (output_text),
        .pop       (pop_req),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_end = (div_cnt == DW'(BIT_DIV - 1));
    // Each payload byte leaves the FIFO on the first cycle of its MSB; that
    // cycle drives the line straight from the FIFO head.
    assign pop_now = (state == DATA) && (div_cnt == '0) && (byte_bit == '0);
    assign pop_req = pop_now && !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        last_bit   = 1'b0;
        cur_bit    = 1'b0;
        tx_valid   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && (fifo_count >= CW'(BYTES_PER_FRAME))) state_nxt = PRE;
            end
            PRE: begin
                tx_valid = 1'b1;
                cur_bit  = PREAMBLE[3'd7 - bit_cnt[2:0]];
                last_bit = (bit_cnt == CNT_W'(7));
                if (bit_end && last_bit) state_nxt = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                cur_bit  = pop_now ? head[DATA_W-1] : shreg[DATA_W-1];
                last_bit = (bit_cnt == CNT_W'(PAY_BITS - 1));
                if (bit_end && last_bit) state_nxt = CRC;
            end
            CRC: begin
                tx_valid = 1'b1;
                cur_bit  = ~crc[4'd15 - bit_cnt[3:0]];
                last_bit = (bit_cnt == CNT_W'(15));
                if (bit_end && last_bit) state_nxt = GAP;
            end
            GAP: begin
                frame_done = (bit_cnt == '0) && (div_cnt == '0);
                last_bit   = (bit_cnt == CNT_W'(GAP_BITS - 1));
                if (bit_end && last_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_bit <= '0;
            shreg    <= '0;
            crc      <= CRC16_INIT;
        end else if (state == IDLE) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_bit <= '0;
            if (state_nxt == PRE) crc <= CRC16_INIT;
        end else begin
            div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
            if (bit_end) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                if (state == DATA) begin
                    // CRC folds in each payload bit once, on its last cycle.
                    crc      <= crc16_step(crc, cur_bit);
                    shreg    <= shreg << 1;
                    byte_bit <= (byte_bit == BW'(DATA_W - 1)) ? '0 : byte_bit + BW'(1);
                end
            end
            if (pop_now) shreg <= head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              overflow <= 1'b0;
        else if (done && fifo_full && !pop_req)  overflow <= 1'b1;
    end

`ifdef RSA_TX_FM0_EN
    // line is the level at the end of the previous bit; it survives between frames.
    logic line;
    logic half2;

    assign half2  = (div_cnt >= DW'(BIT_DIV / 2));
    // Every bit opens inverted; a zero inverts again at mid-bit.
    assign tx_bit = tx_valid & (half2 ? (cur_bit ? ~line : line) : ~line);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    line <= 1'b0;
        else if (tx_valid && bit_end)  line <= cur_bit ? ~line : line;
    end
`else
    assign tx_bit = tx_valid & cur_bit;
`endif

endmodule

// File: tb/tb_rsa_tx_framer.sv
module tb_rsa_tx_framer;

    localparam int BD = 4;
    localparam int GB = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       done, tx_en;
    logic [7:0] output_text;
    logic       tx_bit, tx_valid, frame_done, overflow;
    logic [2:0] fifo_count;

    logic       done9, tx_en9;
    logic [7:0] text9;
    logic       tx_bit9, tx_valid9, frame_done9, overflow9;
    logic [4:0] fifo_count9;

    logic       sel9;
    logic       s_bit, s_valid, s_fd;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] r_bits;
    int           r_vcyc, r_wcyc, r_fd, r_bad;
    logic         r_fd_first, r_timeout, r_ovf_at;
    logic [4:0]   r_cnt_before, r_cnt_at;
`ifdef RSA_TX_FM0_EN
    logic lvl0, lvl9;
`endif

    always #5 clk = ~clk;

    assign s_bit   = sel9 ? tx_bit9     : tx_bit;
    assign s_valid = sel9 ? tx_valid9   : tx_valid;
    assign s_fd    = sel9 ? frame_done9 : frame_done;

    rsa_tx_framer dut (
        .clk         (clk),
        .reset       (reset),
        .done        (done),
        .output_text (output_text),
        .tx_en       (tx_en),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    rsa_tx_framer #(.FIFO_DEPTH(16), .BYTES_PER_FRAME(9)) dut9 (
        .clk         (clk),
        .reset       (reset),
        .done        (done9),
        .output_text (text9),
        .tx_en       (tx_en9),
        .tx_bit      (tx_bit9),
        .tx_valid    (tx_valid9),
        .frame_done  (frame_done9),
        .overflow    (overflow9),
        .fifo_count  (fifo_count9)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clk);
        done = 1'b1;
        output_text = v;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic push9(input logic [7:0] v);
        @(negedge clk);
        done9 = 1'b1;
        text9 = v;
        @(negedge clk);
        done9 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
`ifdef RSA_TX_FM0_EN
        lvl0 = 1'b0;
        lvl9 = 1'b0;
`endif
    endtask

    // Waits for a frame on the selected DUT, decodes one bit per BD cycles,
    // then watches the gap. Optionally pulses done at frame cycle push_at.
    task automatic capture(input int push_at, input logic [7:0] push_val);
        int   ph;
        logic b;
`ifdef RSA_TX_FM0_EN
        logic prev, h1, h2;
        prev = sel9 ? lvl9 : lvl0;
        h1 = 1'b0;
        h2 = 1'b0;
`endif
        b = 1'b0;
        r_bits = '0; r_vcyc = 0; r_wcyc = 0; r_fd = 0; r_bad = 0;
        r_fd_first = 1'b0; r_timeout = 1'b0; r_ovf_at = 1'b0;
        r_cnt_before = '0; r_cnt_at = '0;
        do begin
            @(negedge clk);
            r_wcyc++;
        end while (!s_valid && r_wcyc < 400);
        if (!s_valid) begin
            r_timeout = 1'b1;
            return;
        end
        while (s_valid && r_vcyc < 2000) begin
            ph = r_vcyc % BD;
            r_fd += int'(s_fd);
            if (ph == 0) b = s_bit;
`ifdef RSA_TX_FM0_EN
            if (ph == 0) begin
                h1 = s_bit;
                if (h1 === prev) r_bad++;
            end
            if (ph == BD / 2) h2 = s_bit;
            if (s_bit !== ((ph < BD / 2) ? h1 : h2)) r_bad++;
            if (ph == BD - 1) begin
                r_bits = {r_bits[126:0], h1 === h2};
                prev = h2;
            end
`else
            if (s_bit !== b) r_bad++;
            if (ph == BD - 1) r_bits = {r_bits[126:0], b};
`endif
            if (push_at >= 0 && r_vcyc == push_at) begin
                r_cnt_before = {2'b00, fifo_count};
                done = 1'b1;
                output_text = push_val;
            end
            if (push_at >= 0 && r_vcyc == push_at + 1) begin
                done = 1'b0;
                r_cnt_at = {2'b00, fifo_count};
                r_ovf_at = overflow;
            end
            r_vcyc++;
            @(negedge clk);
        end
        r_fd_first = s_fd;
        for (int i = 0; i < GB * BD; i++) begin
            if (i > 0) @(negedge clk);
            r_fd += int'(s_fd);
            if (s_bit !== 1'b0 || s_valid !== 1'b0) r_bad++;
        end
`ifdef RSA_TX_FM0_EN
        if (sel9) lvl9 = prev;
        else      lvl0 = prev;
`endif
    endtask

    initial begin
        int quiet;
        reset = 1'b0; done = 1'b0; tx_en = 1'b0; output_text = '0;
        done9 = 1'b0; tx_en9 = 1'b0; text9 = '0; sel9 = 1'b0;
`ifdef RSA_TX_FM0_EN
        lvl0 = 1'b0;
        lvl9 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {tx_valid, tx_bit, frame_done, overflow, fifo_count}, '0);
        chk("reset_outputs9", {tx_valid9, tx_bit9, frame_done9, overflow9, fifo_count9}, '0);
        reset = 1'b1;

        // Basic frame: AC 05 2B, ~CRC16(05 2B) = ~77F3 = 880C.
        push(8'h05);
        push(8'h2B);
        chk("t1_count_loaded", fifo_count, 3'd2);
        tx_en = 1'b1;
        capture(-1, 8'h00);
        chk("t1_start", r_timeout, 1'b0);
        chk("t1_bits", r_bits[39:0], 40'hAC052B880C);
        chk("t1_valid_cycles", r_vcyc, 160);
        chk("t1_stable", r_bad, 0);
        chk("t1_done_first_gap", r_fd_first, 1'b1);
        chk("t1_done_count", r_fd, 1);
        chk("t1_count_after", fifo_count, 3'd0);
        tx_en = 1'b0;

        // Nine-byte payload "123456789": trailing 16 bits are the CRC check value D64E.
        for (int i = 0; i < 9; i++) push9(8'h31 + 8'(i));
        chk("t2_count_loaded", fifo_count9, 5'd9);
        tx_en9 = 1'b1;
        sel9 = 1'b1;
        capture(-1, 8'h00);
        sel9 = 1'b0;
        tx_en9 = 1'b0;
        chk("t2_start", r_timeout, 1'b0);
        chk("t2_crc", r_bits[15:0], 16'hD64E);
        chk("t2_bits", r_bits[95:0], 96'hAC313233343536373839D64E);
        chk("t2_valid_cycles", r_vcyc, 384);
        chk("t2_done_count", r_fd, 1);

        // Five pushes into a depth-4 FIFO: fifth byte dropped.
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("t3_count_full", fifo_count, 3'd4);
        chk("t3_overflow", overflow, 1'b1);
        tx_en = 1'b1;
        capture(-1, 8'h00);
        chk("t3_frame_a_payload", r_bits[31:16], 16'h0102);
        chk("t3_frame_a_pre", r_bits[39:32], 8'hAC);
        capture(-1, 8'h00);
        chk("t3_frame_b_payload", r_bits[31:16], 16'h0304);
        chk("t3_gap_spacing", r_wcyc, 2);
        chk("t3_count_drained", fifo_count, 3'd0);
        chk("t3_overflow_sticky", overflow, 1'b1);
        quiet = 0;
        repeat (200) begin
            @(negedge clk);
            quiet += int'(tx_valid);
        end
        chk("t3_no_third_frame", quiet, 0);

        // Reset in the middle of the payload.
        push(8'h05);
        push(8'h2B);
        quiet = 0;
        while (!tx_valid && quiet < 50) begin
            @(negedge clk);
            quiet++;
        end
        chk("t4_started", tx_valid, 1'b1);
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4_abort_outputs", {tx_valid, frame_done, overflow, fifo_count}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
`ifdef RSA_TX_FM0_EN
        lvl0 = 1'b0;
        lvl9 = 1'b0;
`endif
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet += int'(tx_valid) + int'(frame_done);
        end
        chk("t4_idle_after_reset", quiet, 0);
        push(8'h05);
        push(8'h2B);
        capture(-1, 8'h00);
        chk("t4_bits", r_bits[39:0], 40'hAC052B880C);
        chk("t4_done_count", r_fd, 1);

        // Full FIFO with done on the first payload pop cycle.
        tx_en = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("t5_count_full", fifo_count, 3'd4);
        tx_en = 1'b1;
        capture(32, 8'h55);
        chk("t5_count_before", r_cnt_before, 5'd4);
        chk("t5_count_unchanged", r_cnt_at, 5'd4);
        chk("t5_no_overflow", r_ovf_at, 1'b0);
        chk("t5_frame_a_payload", r_bits[31:16], 16'h1122);
        capture(-1, 8'h00);
        chk("t5_frame_b_payload", r_bits[31:16], 16'h3344);
        chk("t5_count_left", fifo_count, 3'd1);
        chk("t5_overflow_clear", overflow, 1'b0);

        // Payload 00 FF: all-zero and all-one bytes on the line.
        tx_en = 1'b0;
        pulse_reset();
        push(8'h00);
        push(8'hFF);
        tx_en = 1'b1;
        capture(-1, 8'h00);
        chk("t6_head", r_bits[39:16], 24'hAC00FF);
        chk("t6_valid_cycles", r_vcyc, 160);
        chk("t6_line_shape", r_bad, 0);
        chk("t6_done_count", r_fd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rsa_tx_framer.md
Name: rsa_tx_framer

Overview:
Downstream stage of rsa_rfid. Captures each ciphertext byte on the done pulse and buffers it in a small FIFO. Once a full payload is buffered, it serializes a reader-bound frame of preamble, payload and CRC-16 onto a single bit line for the UHF RFID backscatter front end. This decouples RSA completion timing from air-interface bit timing.

Parameters:
DATA_W, 8, width of output_text and of each payload byte
FIFO_DEPTH, 4, ciphertext buffer entries (power of 2, >= BYTES_PER_FRAME)
BYTES_PER_FRAME, 2, payload bytes per frame
BIT_DIV, 4, clk cycles per transmitted bit (even, >= 2)
GAP_BITS, 2, idle bit-times enforced between frames

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
done  in  1  one-cycle pulse from rsa_rfid; qualifies output_text
output_text  in  DATA_W  ciphertext byte from rsa_rfid
tx_en  in  1  permits a new frame to start
tx_bit  out  1  serial line level
tx_valid  out  1  high for every bit-time of a frame
frame_done  out  1  one-cycle pulse after the last CRC bit
overflow  out  1  sticky: a byte was dropped on a full FIFO
fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-low. While reset=0: tx_bit=0, tx_valid=0, frame_done=0, overflow=0, fifo_count=0, FSM=IDLE, FIFO emptied, CRC register=16'hFFFF.
- Reset mid-frame aborts the frame immediately. No frame_done is produced and buffered bytes are lost.
- Push: done=1 with FIFO not full writes output_text. done=1 with FIFO full drops the byte and sets overflow, which stays set until reset.
- Push and pop in the same cycle are both accepted, even when the FIFO is full. fifo_count is then unchanged.
- FSM states: IDLE, PRE, DATA, CRC, GAP.
- IDLE→PRE when tx_en=1 and fifo_count>=BYTES_PER_FRAME. tx_valid rises and the first preamble bit appears on the next clk edge.
- PRE: sends the 8-bit preamble constant, MSB first.
- PRE→DATA: the first payload byte is popped on the cycle its first bit starts.
- DATA: sends BYTES_PER_FRAME bytes, MSB first. Each byte is popped at the start of its MSB.
- CRC: sends the ones-complement of CRC-16, MSB first.
  - Polynomial 16'h1021, init 16'hFFFF, unreflected.
  - Computed over payload bits only, one bit per bit-time.
- CRC→GAP: frame_done pulses on the first GAP cycle.
- GAP: tx_valid=0, tx_bit=0 for GAP_BITS*BIT_DIV cycles, then →IDLE.
- Each bit is held exactly BIT_DIV cycles by a bit-period counter.
- Frame length is 8+8*BYTES_PER_FRAME+16 bits. tx_valid is high for exactly that many bits times BIT_DIV cycles, contiguously.
- tx_en is sampled only in IDLE. Deasserting it mid-frame does not truncate the frame.
- done pulses arriving during a frame are buffered normally.
- The CRC register reloads 16'hFFFF on entry to PRE.
- Outside frames: tx_bit=0.

Optional Feature:
- Macro: RSA_TX_FM0_EN.
- Defined: tx_bit carries an FM0-encoded line.
  - The line level inverts at the start of every bit.
  - A data-0 also inverts at BIT_DIV/2.
  - The line level register resets to 0 and holds between frames.
  - The encoding applies to preamble, payload and CRC alike.
- Undefined: tx_bit is plain NRZ, equal to the current bit.
- All other timing, tx_valid and frame_done are identical in both builds.

Decomposition:
- Package rsa_rfid_pkg holds:
  - PREAMBLE = 8'hAC
  - CRC16_POLY = 16'h1021 and CRC16_INIT = 16'hFFFF
  - the FSM state enum
  - a pure crc16_step(crc, bit) function
- One sub-module, rsa_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by DATA_W and FIFO_DEPTH.
- FSM, bit counter, CRC and encoder stay in rsa_tx_framer.

Test Plan:
- Defaults, NRZ build. Pulse done with 8'h05 then 8'h2B, tx_en=1.
  - tx_valid is high for exactly 160 cycles.
  - Bits are 10101100, 00000101, 00101011, then ~CRC16(05 2B) MSB-first.
  - frame_done pulses once; fifo_count is 0 afterwards.
- BYTES_PER_FRAME=9, FIFO_DEPTH=16. Push ASCII "123456789".
  - The last 16 bits on tx_bit equal 16'hD64E.
- tx_en=0, five done pulses (values 1..5).
  - fifo_count=4 and overflow=1.
  - After tx_en=1, the first frame carries 01 02, the second 03 04, and 05 never appears.
- Push 2 bytes with tx_en=1 and assert reset=0 during DATA.
  - tx_valid=0 and fifo_count=0 immediately.
  - No frame_done; overflow=0.
  - After release, the FSM is in IDLE and a new 2-byte push produces a correct frame.
- FIFO full during a frame, with done coinciding with a pop cycle.
  - The byte is accepted, overflow stays 0, fifo_count is unchanged.
- RSA_TX_FM0_EN build, payload 8'h00 8'hFF.
  - Each payload-0 bit shows a transition at the bit start and at BIT_DIV/2.
  - Each payload-1 bit shows a transition only at the bit start.
  - tx_valid timing is identical to the NRZ run.
